// File: rtl/alien_formation_mover.sv
// -----------------------------------------------------------------------------
// alien_formation_mover
//
// Purpose:
//   Executes the per-step motion commands of the alien formation. A step timer
//   issues a periodic one-cycle step_tick to the upstream zig-zag motion
//   controller. One cycle later (move_strobe) the controller's one-hot motion
//   code is applied to the formation position. The block feeds back whether a
//   left or right step is possible. It shortens the step period after every
//   downward step. It raises a sticky flag once the formation has landed.
//
// Ports:
//   clk            in   1   system clock
//   reset          in   1   synchronous, active-high reset
//   motion         in   3   one-hot motion code: bit2 right, bit1 down,
//                           bit0 left, 000 none
//   pause          in   1   freezes the step timer
//   step_tick      out  1   one-cycle enable pulse to the motion controller
//   can_left       out  1   a left step is possible from the current X
//   can_right      out  1   a right step is possible from the current X
//   x_pos          out  10  formation left-edge X
//   y_pos          out  10  formation top-edge Y
//   step_period    out  26  current cycles per step
//   reached_bottom out  1   sticky landed flag, halts the step timer
//   illegal_motion out  1   sticky flag for a nonzero, non-one-hot motion code
// -----------------------------------------------------------------------------
module alien_formation_mover #(
  parameter int X_START       = 16,
  parameter int Y_START       = 0,
  parameter int X_MIN         = 0,
  parameter int X_RIGHT_LIMIT = 32,
  parameter int STEP_X        = 8,
  parameter int STEP_Y        = 8,
  parameter int Y_BOTTOM      = 24,
  parameter int PERIOD_INIT   = 4,
  parameter int PERIOD_DEC    = 1,
  parameter int PERIOD_MIN    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  motion,
  input  logic        pause,
  output logic        step_tick,
  output logic        can_left,
  output logic        can_right,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [25:0] step_period,
  output logic        reached_bottom,
  output logic        illegal_motion
);

  // Motion codes from the controller. There is no FSM here. These constants
  // name the only legal codes.
  localparam logic [2:0] MOTION_NONE  = 3'b000;
  localparam logic [2:0] MOTION_LEFT  = 3'b001;
  localparam logic [2:0] MOTION_DOWN  = 3'b010;
  localparam logic [2:0] MOTION_RIGHT = 3'b100;

  // Position constants in register width (10 bits). Compare constants are
  // one bit wider (11 bits) so that x/y plus a step cannot wrap before the
  // saturation test.
  localparam logic [9:0]  X_START_P     = 10'(X_START);
  localparam logic [9:0]  Y_START_P     = 10'(Y_START);
  localparam logic [9:0]  X_MIN_P       = 10'(X_MIN);
  localparam logic [9:0]  X_RIGHT_P     = 10'(X_RIGHT_LIMIT);
  localparam logic [9:0]  STEP_X_P      = 10'(STEP_X);
  localparam logic [9:0]  Y_BOTTOM_P    = 10'(Y_BOTTOM);
  localparam logic [10:0] STEP_X_W      = 11'(STEP_X);
  localparam logic [10:0] STEP_Y_W      = 11'(STEP_Y);
  localparam logic [10:0] X_RIGHT_W     = 11'(X_RIGHT_LIMIT);
  localparam logic [10:0] Y_BOTTOM_W    = 11'(Y_BOTTOM);
  localparam logic [10:0] LEFT_THRESH_W = 11'(X_MIN + STEP_X);

  // Period constants. PERIOD_SHRINK_MIN is the smallest period that can still
  // be reduced by PERIOD_DEC without going below the floor.
  localparam logic [25:0] PERIOD_INIT_P     = 26'(PERIOD_INIT);
  localparam logic [25:0] PERIOD_DEC_P      = 26'(PERIOD_DEC);
  localparam logic [25:0] PERIOD_MIN_P      = 26'(PERIOD_MIN);
  localparam logic [25:0] PERIOD_SHRINK_MIN = 26'(PERIOD_MIN + PERIOD_DEC);

  logic [25:0] count;
  logic        move_strobe;
  logic        timer_run;
  logic        timer_expired;

  logic        is_left;
  logic        is_right;
  logic        is_down;
  logic        is_bad;

  logic [10:0] right_sum;
  logic [10:0] down_sum;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic [25:0] period_next;
  logic        illegal_next;
  logic        bottom_next;

  // The timer only advances while the game is running: not paused and not
  // landed. The >= compare, rather than ==, means a period that shrinks
  // below the current count still expires on the next compare instead of
  // wrapping through 2^26 cycles.
  always_comb begin
    timer_run     = !pause && !reached_bottom;
    timer_expired = (count >= (step_period - 26'd1));
  end

  // Step timer and registered step_tick. When the timer is frozen the
  // count holds its value, so a paused step resumes where it stopped
  // instead of starting a fresh period.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 26'd0;
      step_tick <= 1'b0;
    end else if (!timer_run) begin
      step_tick <= 1'b0;
    end else if (timer_expired) begin
      count     <= 26'd0;
      step_tick <= 1'b1;
    end else begin
      count     <= count + 26'd1;
      step_tick <= 1'b0;
    end
  end

  // move_strobe trails step_tick by one cycle. The controller changes state
  // on the tick edge, so its motion code is only valid in this later cycle.
  // move_strobe is not gated by pause or reached_bottom, so a move that is
  // already in flight still completes. Reset clears it, which discards a
  // pending move.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_strobe <= 1'b0;
    end else begin
      move_strobe <= step_tick;
    end
  end

  // Decode the motion code. Only the three one-hot codes and 000 are
  // meaningful. Any other nonzero code is flagged and produces no movement.
  always_comb begin
    is_left  = (motion == MOTION_LEFT);
    is_right = (motion == MOTION_RIGHT);
    is_down  = (motion == MOTION_DOWN);
    is_bad   = (motion != MOTION_NONE) && !is_left && !is_right && !is_down;
  end

  // Candidate sums are computed 11 bits wide, so the saturation test sees the
  // true value even near the top of the 10-bit range. can_left and
  // can_right depend only on the registered x_pos, so the controller sees
  // them settle within the current cycle.
  always_comb begin
    right_sum = {1'b0, x_pos} + STEP_X_W;
    down_sum  = {1'b0, y_pos} + STEP_Y_W;
    can_left  = ({1'b0, x_pos} >= LEFT_THRESH_W);
    can_right = (right_sum <= X_RIGHT_W);
  end

  // Next-state for position, period and illegal flag. Motion is ignored
  // outside move_strobe. A left step compares against the threshold before
  // subtracting, so x never wraps below X_MIN. A down step also shortens
  // the period, down to the floor.
  always_comb begin
    x_next       = x_pos;
    y_next       = y_pos;
    period_next  = step_period;
    illegal_next = illegal_motion;
    if (move_strobe) begin
      if (is_right) begin
        if (right_sum > X_RIGHT_W) begin
          x_next = X_RIGHT_P;
        end else begin
          x_next = right_sum[9:0];
        end
      end else if (is_left) begin
        if ({1'b0, x_pos} < LEFT_THRESH_W) begin
          x_next = X_MIN_P;
        end else begin
          x_next = x_pos - STEP_X_P;
        end
      end else if (is_down) begin
        if (down_sum >= Y_BOTTOM_W) begin
          y_next = Y_BOTTOM_P;
        end else begin
          y_next = down_sum[9:0];
        end
        if (step_period < PERIOD_SHRINK_MIN) begin
          period_next = PERIOD_MIN_P;
        end else begin
          period_next = step_period - PERIOD_DEC_P;
        end
      end else if (is_bad) begin
        illegal_next = 1'b1;
      end
    end
    bottom_next = reached_bottom || ({1'b0, y_next} >= Y_BOTTOM_W);
  end

  // Formation state registers. reached_bottom is set on the same edge that
  // y_pos reaches the bottom row. From the next cycle on it freezes the
  // timer, and it stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_pos          <= X_START_P;
      y_pos          <= Y_START_P;
      step_period    <= PERIOD_INIT_P;
      reached_bottom <= 1'b0;
      illegal_motion <= 1'b0;
    end else begin
      x_pos          <= x_next;
      y_pos          <= y_next;
      step_period    <= period_next;
      reached_bottom <= bottom_next;
      illegal_motion <= illegal_next;
    end
  end

endmodule

// File: tb/tb_alien_formation_mover.sv
// -----------------------------------------------------------------------------
// tb_alien_formation_mover
//
// Purpose:
//   Self-checking bench for alien_formation_mover with default parameters.
//   Each motion command is driven in the cycle after a step_tick. At the
//   same time the bench pushes the expected formation state, computed from
//   its own model, onto a scoreboard queue. Two cycles after the tick the
//   entry is popped and compared with the DUT outputs.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_alien_formation_mover;

  localparam int X_START       = 16;
  localparam int Y_START       = 0;
  localparam int X_MIN         = 0;
  localparam int X_RIGHT_LIMIT = 32;
  localparam int STEP_X        = 8;
  localparam int STEP_Y        = 8;
  localparam int Y_BOTTOM      = 24;
  localparam int PERIOD_INIT   = 4;
  localparam int PERIOD_DEC    = 1;
  localparam int PERIOD_MIN    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  motion;
  logic        pause;
  logic        step_tick;
  logic        can_left;
  logic        can_right;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [25:0] step_period;
  logic        reached_bottom;
  logic        illegal_motion;

  typedef struct {
    string       tag;
    int          x;
    int          y;
    int          period;
    logic        rb;
    logic        il;
  } exp_t;

  exp_t sb[$];

  int   checks_total  = 0;
  int   checks_passed = 0;
  int   cyc           = 0;
  int   last_tick_cyc = 0;
  logic [2:0] idle_motion;

  int   mx;
  int   my;
  int   mp;
  logic mrb;
  logic mil;

  alien_formation_mover #(
    .X_START      (X_START),
    .Y_START      (Y_START),
    .X_MIN        (X_MIN),
    .X_RIGHT_LIMIT(X_RIGHT_LIMIT),
    .STEP_X       (STEP_X),
    .STEP_Y       (STEP_Y),
    .Y_BOTTOM     (Y_BOTTOM),
    .PERIOD_INIT  (PERIOD_INIT),
    .PERIOD_DEC   (PERIOD_DEC),
    .PERIOD_MIN   (PERIOD_MIN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .motion        (motion),
    .pause         (pause),
    .step_tick     (step_tick),
    .can_left      (can_left),
    .can_right     (can_right),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .step_period   (step_period),
    .reached_bottom(reached_bottom),
    .illegal_motion(illegal_motion)
  );

  // Free-running clock and an edge counter used to measure tick spacing.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something keeps the main sequence from finishing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Model state after reset.
  task automatic modelReset;
    mx  = X_START;
    my  = Y_START;
    mp  = PERIOD_INIT;
    mrb = 1'b0;
    mil = 1'b0;
  endtask

  // Apply one motion command to the model and push the expected result.
  task automatic modelMove(input string tag, input logic [2:0] code);
    exp_t e;
    case (code)
      3'b100: mx = (mx + STEP_X > X_RIGHT_LIMIT) ? X_RIGHT_LIMIT : mx + STEP_X;
      3'b001: mx = (mx < X_MIN + STEP_X) ? X_MIN : mx - STEP_X;
      3'b010: begin
        my = (my + STEP_Y >= Y_BOTTOM) ? Y_BOTTOM : my + STEP_Y;
        mp = (mp - PERIOD_DEC < PERIOD_MIN) ? PERIOD_MIN : mp - PERIOD_DEC;
      end
      3'b000: ;
      default: mil = 1'b1;
    endcase
    if (my >= Y_BOTTOM) mrb = 1'b1;
    e.tag    = tag;
    e.x      = mx;
    e.y      = my;
    e.period = mp;
    e.rb     = mrb;
    e.il     = mil;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic checkScoreboard;
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({e.tag, "_x"}, 32'(x_pos), 32'(e.x));
      checkOutput({e.tag, "_y"}, 32'(y_pos), 32'(e.y));
      checkOutput({e.tag, "_period"}, 32'(step_period), 32'(e.period));
      checkOutput({e.tag, "_bottom"}, 32'(reached_bottom), 32'(e.rb));
      checkOutput({e.tag, "_illegal"}, 32'(illegal_motion), 32'(e.il));
      checkOutput({e.tag, "_can_left"}, 32'(can_left),
                  32'(e.x >= X_MIN + STEP_X));
      checkOutput({e.tag, "_can_right"}, 32'(can_right),
                  32'(e.x + STEP_X <= X_RIGHT_LIMIT));
    end
  endtask

  // Wait (bounded) for the next step_tick. Optionally check its spacing
  // from the previous tick.
  task automatic waitTick(input string tag, input int exp_interval);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_tick && n < 64);
    if (!step_tick) begin
      checkOutput({tag, "_tick_timeout"}, 32'd0, 32'd1);
    end else if (exp_interval > 0) begin
      checkOutput({tag, "_tick_interval"}, 32'(cyc - last_tick_cyc),
                  32'(exp_interval));
    end
    last_tick_cyc = cyc;
  endtask

  // One step: wait for the tick and present the code for the strobe cycle.
  // Record the expectation, then compare once the position has updated.
  task automatic applyStimulus(input string tag, input logic [2:0] code,
                               input int exp_interval,
                               input bit pause_in_flight);
    waitTick(tag, exp_interval);
    motion = code;
    if (pause_in_flight) pause = 1'b1;
    modelMove(tag, code);
    @(negedge clk);
    @(negedge clk);
    checkScoreboard();
    pause  = 1'b0;
    motion = idle_motion;
  endtask

  initial begin
    reset       = 1'b1;
    pause       = 1'b0;
    motion      = 3'b000;
    idle_motion = 3'b000;
    modelReset();

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_x", 32'(x_pos), 32'(X_START));
    checkOutput("rst_y", 32'(y_pos), 32'(Y_START));
    checkOutput("rst_period", 32'(step_period), 32'(PERIOD_INIT));
    checkOutput("rst_tick", 32'(step_tick), 32'd0);
    checkOutput("rst_bottom", 32'(reached_bottom), 32'd0);
    checkOutput("rst_illegal", 32'(illegal_motion), 32'd0);

    // Idle march: ticks on cycles 4, 8, 12, 16, 20 after release.
    reset = 1'b0;
    last_tick_cyc = cyc;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_tick_c%0d", k), 32'(step_tick),
                  32'((k % PERIOD_INIT) == 0));
      checkOutput("idle_x", 32'(x_pos), 32'(X_START));
      checkOutput("idle_y", 32'(y_pos), 32'(Y_START));
      checkOutput("idle_can_left", 32'(can_left), 32'd1);
      checkOutput("idle_can_right", 32'(can_right), 32'd1);
    end
    last_tick_cyc = cyc;

    // Right steps up to saturation. Between strobes a junk code is driven,
    // and it must be ignored.
    applyStimulus("right1", 3'b100, 4, 1'b0);
    idle_motion = 3'b111;
    motion      = idle_motion;
    applyStimulus("right2", 3'b100, 4, 1'b0);
    applyStimulus("right_sat", 3'b100, 4, 1'b0);

    // Left steps down to X_MIN, with no wrap below zero.
    applyStimulus("left1", 3'b001, 4, 1'b0);
    applyStimulus("left2", 3'b001, 4, 1'b0);
    applyStimulus("left3", 3'b001, 4, 1'b0);
    applyStimulus("left4", 3'b001, 4, 1'b0);
    idle_motion = 3'b000;
    applyStimulus("left_sat", 3'b001, 4, 1'b0);

    // Pause raised between tick and strobe: the move completes. The timer
    // is frozen for the two paused edges, so the next tick is 2 cycles late.
    applyStimulus("pause_inflight", 3'b100, 4, 1'b1);
    waitTick("pause_resume", PERIOD_INIT + 2);

    // Pause with count = 3, one edge before the next tick would fire.
    repeat (3) @(negedge clk);
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("paused_tick", 32'(step_tick), 32'd0);
    end
    pause = 1'b0;
    @(negedge clk);
    checkOutput("tick_after_pause", 32'(step_tick), 32'd1);
    checkOutput("pause_x_hold", 32'(x_pos), 32'(mx));
    last_tick_cyc = cyc;

    // Non-one-hot code: no movement, sticky illegal flag.
    applyStimulus("illegal", 3'b101, 4, 1'b0);

    // Reset one cycle after a tick discards the pending right move.
    waitTick("rst_inflight", 4);
    motion = 3'b100;
    reset  = 1'b1;
    @(negedge clk);
    modelReset();
    checkOutput("rst2_x", 32'(x_pos), 32'(X_START));
    checkOutput("rst2_y", 32'(y_pos), 32'(Y_START));
    checkOutput("rst2_period", 32'(step_period), 32'(PERIOD_INIT));
    checkOutput("rst2_tick", 32'(step_tick), 32'd0);
    checkOutput("rst2_bottom", 32'(reached_bottom), 32'd0);
    checkOutput("rst2_illegal", 32'(illegal_motion), 32'd0);
    reset = 1'b0;
    last_tick_cyc = cyc;
    @(negedge clk);
    checkOutput("rst2_move_discarded", 32'(x_pos), 32'(X_START));
    motion = 3'b000;

    // Down steps: the period shrinks to its floor and the formation lands.
    // The 3->2 change lands after the strobe-edge compare has already used
    // the old period, so that one interval is not checked.
    applyStimulus("down1", 3'b010, 4, 1'b0);
    applyStimulus("down2", 3'b010, 3, 1'b0);
    applyStimulus("down3", 3'b010, 0, 1'b0);

    // Any tick issued on the landing edge finishes its strobe. After that
    // the timer stays halted.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("landed_no_tick", 32'(step_tick), 32'd0);
    end
    checkOutput("landed_y", 32'(y_pos), 32'(Y_BOTTOM));
    checkOutput("landed_bottom", 32'(reached_bottom), 32'd1);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
